// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: iterative signed 32x32 multiply and 32/32 divide unit
// with HI/LO result registers.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   reset      - synchronous, active-high reset
//   mult_start - start a signed multiply of a and b (wins over div_start)
//   div_start  - start a signed divide, a / b
//   a, b       - operands, sampled only when a start is accepted in IDLE
//   busy       - high while an operation is in RUN or FIX
//   done       - one-cycle completion pulse
//   div_zero   - divide-by-zero flag; meaningful only while done is high
//   hi, lo     - result registers (product high/low, or remainder/quotient)
//
// Build option:
//   DIV_ZERO_TRAP_EN - when defined, a divide with b == 0 skips the iteration
//                      sequence, pulses done with div_zero set and leaves
//                      hi/lo untouched. When undefined, it runs the normal
//                      sequence and div_zero stays 0.
//
// Timing from the accepting edge E0: the first RUN edge forms operand
// magnitudes, the next 32 RUN edges iterate, the FIX edge (E0+34) applies
// the signs and writes hi/lo, and done is high in the following cycle.

module mult_div_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        mult_start,
   input  logic        div_start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        is_mult_q, is_mult_d;
   logic        neg_a_q, neg_a_d;
   logic        neg_b_q, neg_b_d;
   logic [31:0] acc_q, acc_d;   // mult: product upper half; div: partial remainder
   logic [31:0] sh_q, sh_d;     // mult: multiplier -> product lower; div: dividend -> quotient
   logic [31:0] opb_q, opb_d;   // multiplicand or divisor magnitude
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        dz_q, dz_d;

   logic        start;
   logic        div_trap;
   logic [32:0] mul_sum;
   logic [32:0] div_sh;
   logic [31:0] div_diff;
   logic        div_ge;
   logic [63:0] prod;
   logic [63:0] prod_neg;

   function automatic logic [31:0] abs32(input logic [31:0] x);
      // 0x80000000 maps to itself, which is the correct unsigned magnitude
      return x[31] ? (32'd0 - x) : x;
   endfunction

   assign start = mult_start | div_start;

`ifdef DIV_ZERO_TRAP_EN
   assign div_trap = div_start & ~mult_start & (b == 32'd0);
`else
   assign div_trap = 1'b0;
`endif

   // Shift-add step: conditionally add multiplicand to upper half, then
   // shift the 64-bit {acc, sh} pair right by one.
   assign mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : 33'd0);

   // Restoring divide step: shift next dividend bit into the remainder and
   // subtract the divisor if it fits. The remainder stays below the divisor,
   // so the 32-bit difference never overflows.
   assign div_sh   = {acc_q, sh_q[31]};
   assign div_ge   = (div_sh >= {1'b0, opb_q});
   assign div_diff = div_sh[31:0] - opb_q;

   assign prod     = {acc_q, sh_q};
   assign prod_neg = 64'd0 - prod;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         is_mult_q <= 1'b0;
         neg_a_q   <= 1'b0;
         neg_b_q   <= 1'b0;
         acc_q     <= '0;
         sh_q      <= '0;
         opb_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_mult_q <= is_mult_d;
         neg_a_q   <= neg_a_d;
         neg_b_q   <= neg_b_d;
         acc_q     <= acc_d;
         sh_q      <= sh_d;
         opb_q     <= opb_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dz_q      <= dz_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = div_trap ? DONE : RUN;
         RUN:  if (cnt_q == 6'd32) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      cnt_d     = cnt_q;
      is_mult_d = is_mult_q;
      neg_a_d   = neg_a_q;
      neg_b_d   = neg_b_q;
      acc_d     = acc_q;
      sh_d      = sh_q;
      opb_d     = opb_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dz_d      = dz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               is_mult_d = mult_start;
               neg_a_d   = a[31];
               neg_b_d   = b[31];
               sh_d      = a;
               opb_d     = b;
               acc_d     = '0;
               cnt_d     = '0;
               dz_d      = div_trap;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd0) begin
               // Magnitude setup; multiply keeps |b| in the shifter as the
               // multiplier so its low bit drives each add.
               acc_d = '0;
               if (is_mult_q) begin
                  sh_d  = abs32(opb_q);
                  opb_d = abs32(sh_q);
               end else begin
                  sh_d  = abs32(sh_q);
                  opb_d = abs32(opb_q);
               end
            end else if (is_mult_q) begin
               acc_d = mul_sum[32:1];
               sh_d  = {mul_sum[0], sh_q[31:1]};
            end else if (div_ge) begin
               acc_d = div_diff;
               sh_d  = {sh_q[30:0], 1'b1};
            end else begin
               acc_d = div_sh[31:0];
               sh_d  = {sh_q[30:0], 1'b0};
            end
         end
         FIX: begin
            if (is_mult_q) begin
               hi_d = (neg_a_q ^ neg_b_q) ? prod_neg[63:32] : prod[63:32];
               lo_d = (neg_a_q ^ neg_b_q) ? prod_neg[31:0]  : prod[31:0];
            end else begin
               // Quotient truncates toward zero; remainder follows dividend sign
               lo_d = (neg_a_q ^ neg_b_q) ? (32'd0 - sh_q) : sh_q;
               hi_d = neg_a_q ? (32'd0 - acc_q) : acc_q;
            end
         end
         DONE: dz_d = 1'b0;
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      busy     = (state_q == RUN) || (state_q == FIX);
      done     = (state_q == DONE);
      div_zero = (state_q == DONE) && dz_q;
      hi       = hi_q;
      lo       = lo_q;
   end

endmodule

// File: tb/tb_mult_div_ctrl.sv
module tb_mult_div_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        mult_start, div_start;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  mult_div_ctrl dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_tot = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          st;
    int          lat;   // -1: latency not checked
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", {63'd0, done}, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("result_hi", hi, mon_e.hi);
        chk("result_lo", lo, mon_e.lo);
        chk("result_div_zero", div_zero, mon_e.dz);
        if (mon_e.lat >= 0) chk("done_latency", 64'(cyc - mon_e.st), 64'(mon_e.lat));
      end
    end else if (div_zero !== 1'b0) begin
      chk("div_zero_without_done", {63'd0, div_zero}, 64'd0);
    end
  end

  task automatic do_op(input string nm, input logic m, input logic d,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eh, input logic [31:0] el,
                       input logic edz, input int lat, input bit inj);
    int   k, bad;
    exp_t e;
    @(negedge clk);
    mult_start = m; div_start = d; a = av; b = bv;
    @(posedge clk); #1;
    e.hi = eh; e.lo = el; e.dz = edz; e.st = cyc; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0;
    k = 0; bad = 0;
    while (done !== 1'b1 && k < 60) begin
      if (busy !== (k <= 33)) bad++;
      if (k == 10) begin
        chk({nm, "_hold_hi"}, hi, m_hi);
        chk({nm, "_hold_lo"}, lo, m_lo);
      end
      if (inj && k == 4) begin div_start = 1'b1; a = 32'd9; b = 32'd1; end
      if (inj && k == 5) div_start = 1'b0;
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) chk({nm, "_timeout"}, {63'd0, done}, 64'd1);
    if (lat >= 0) chk({nm, "_busy_window"}, 64'(bad), 64'd0);
    m_hi = eh; m_lo = el;
    @(negedge clk);
  endtask

  initial begin
    int bad;
    reset = 1'b1; mult_start = 1'b0; div_start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_div_zero", div_zero, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    reset = 1'b0;

    do_op("mul_3_m5",     1, 0, 32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 34, 0);
    do_op("div_m7_2",     0, 1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34, 0);
    do_op("div_7_m2",     0, 1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0, 34, 0);
    do_op("mul_min_min",  1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         0, 34, 0);
    do_op("div_min_m1",   0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0, 34, 0);
    do_op("both_start",   1, 1, 32'd2,         32'd3,         32'd0,         32'd6,         0, 34, 1);
    do_op("preload",      1, 0, 32'h66,        32'h2AAA_AAAB, 32'h11,        32'h22,        0, 34, 0);
`ifdef DIV_ZERO_TRAP_EN
    do_op("div_by_zero",  0, 1, 32'd7,         32'd0,         32'h11,        32'h22,        1, -1, 0);
`else
    do_op("div_by_zero",  0, 1, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 0, 34, 0);
`endif
    do_op("div_100_7",    0, 1, 32'd100,       32'd7,         32'd2,         32'd14,        0, 34, 0);

    // Abort a multiply with reset sampled at E0+10
    @(negedge clk); mult_start = 1'b1; a = 32'd5; b = 32'd7;
    @(negedge clk); mult_start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    reset = 1'b0;
    bad = 0;
    repeat (40) begin @(negedge clk); if (done !== 1'b0) bad++; end
    chk("abort_no_done", 64'(bad), 0);
    m_hi = 32'd0; m_lo = 32'd0;

    do_op("mul_m1_m1",    1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         0, 34, 0);

    // Reset wins over a simultaneous start
    @(negedge clk); reset = 1'b1; mult_start = 1'b1; a = 32'd4; b = 32'd4;
    @(negedge clk);
    chk("reset_prio_busy", busy, 0);
    chk("reset_prio_lo", lo, 0);
    reset = 1'b0; mult_start = 1'b0;
    repeat (40) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
